// File: rtl/rom_stream_reader.sv
// Reads len consecutive words from a registered 8x4-style ROM starting at base
// and replays them as a valid/ready stream. Optional checksum: ROM_READER_CHECKSUM_EN.
module rom_stream_reader #(
   parameter int ADDR_W     = 3,
   parameter int DATA_W     = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W:0]   len,
   output logic              rom_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic              busy,
   output logic              done,
   output logic [7:0]        checksum
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int OCC_W = CNT_W + 1;
   localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

   // Handshake: a word transfers on any rising edge where out_valid && out_ready;
   // out_valid never drops and out_data never changes until that transfer happens.

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
   state_t state, state_nxt;

   logic [ADDR_W-1:0] addr_cnt;
   logic [ADDR_W:0]   issue_cnt;
   logic [ADDR_W:0]   deliver_cnt;
   logic              cap_v;
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  fifo_cnt;
   logic [OCC_W-1:0]  occupancy;
   logic              accept, issue, push, pop, last_pop;

   // Credits cover words already queued plus reads still in the ROM pipeline.
   assign occupancy = OCC_W'(fifo_cnt) + OCC_W'(rom_en) + OCC_W'(cap_v);
   assign accept    = (state == IDLE) && start && (len != '0);
   assign push      = cap_v;
   assign pop       = out_valid && out_ready;
   assign last_pop  = pop && (deliver_cnt == LEN_ONE);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = (len == LEN_ONE) ? DRAIN : READ;
         READ:    if (issue && issue_cnt == LEN_ONE) state_nxt = DRAIN;
         DRAIN:   if (last_pop) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      issue     = accept ||
                  ((state == READ) && (issue_cnt != '0) &&
                   (occupancy < OCC_W'(FIFO_DEPTH)));
      busy      = (state != IDLE);
      out_valid = (fifo_cnt != '0);
      out_data  = out_valid ? mem[rd_ptr] : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rom_en      <= 1'b0;
         rom_addr    <= '0;
         addr_cnt    <= '0;
         issue_cnt   <= '0;
         deliver_cnt <= '0;
         cap_v       <= 1'b0;
         done        <= 1'b0;
      end else begin
         rom_en <= issue;
         cap_v  <= rom_en;
         done   <= (state == DRAIN) && last_pop;
         if (accept) begin
            rom_addr    <= base;
            addr_cnt    <= base + ADDR_W'(1);
            issue_cnt   <= len - LEN_ONE;
            deliver_cnt <= len;
         end else begin
            if (issue) begin
               rom_addr  <= addr_cnt;
               addr_cnt  <= addr_cnt + ADDR_W'(1);
               issue_cnt <= issue_cnt - LEN_ONE;
            end
            if (pop) deliver_cnt <= deliver_cnt - LEN_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // Storage is left unreset; out_data is gated by out_valid instead.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= rom_data;
   end

`ifdef ROM_READER_CHECKSUM_EN
   logic [7:0] sum_q;

   always_ff @(posedge clk) begin
      if (!rst_n)      sum_q <= 8'h00;
      else if (accept) sum_q <= 8'h00;
      else if (pop)    sum_q <= sum_q + 8'(out_data);
   end

   assign checksum = sum_q;
`else
   assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench for rom_stream_reader against a registered ROM model holding
// 10,11,12,13,14,15,0,8. Expectations follow ROM_READER_CHECKSUM_EN when defined.
module tb_rom_stream_reader;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [2:0] base;
   logic [3:0] len;
   logic       rom_en;
   logic [2:0] rom_addr;
   logic [3:0] rom_data;
   logic       out_valid;
   logic [3:0] out_data;
   logic       out_ready;
   logic       busy;
   logic       done;
   logic [7:0] checksum;

   logic [3:0] image [8];
   logic [3:0] exp_q[$];
   logic [3:0] got_q[$];
   int         tests_run = 0;
   int         fails     = 0;
   int         en_cnt    = 0;
   int         done_cnt  = 0;

   // ---------------- clock / reset / DUT ----------------
   always #5 clk = ~clk;

   rom_stream_reader #(.ADDR_W(3), .DATA_W(4), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base(base), .len(len),
      .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .busy(busy), .done(done), .checksum(checksum)
   );

   initial begin
      image[0] = 4'd10; image[1] = 4'd11; image[2] = 4'd12; image[3] = 4'd13;
      image[4] = 4'd14; image[5] = 4'd15; image[6] = 4'd0;  image[7] = 4'd8;
      rom_data = 4'd0;
   end

   always @(posedge clk) if (rom_en) rom_data <= image[rom_addr];

   // Monitor on the falling edge: delivered words, ROM reads, done pulses.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) got_q.push_back(out_data);
      if (rom_en) en_cnt++;
      if (done) done_cnt++;
   end

   // ---------------- driver / checker tasks ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_stream(input string tag);
      check({tag, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("%s_word%0d", tag, i), got_q[i], exp_q[i]);
   endtask

   task automatic wait_done(input int bound, input string tag);
      int n = 0;
      while (done !== 1'b1 && n < bound) begin
         step();
         n++;
      end
      check(tag, done, 1);
   endtask

   task automatic launch(input logic [2:0] b, input logic [3:0] l);
      start = 1'b1;
      base  = b;
      len   = l;
      step();
      start = 1'b0;
   endtask

   task automatic load_exp(input int b, input int l);
      exp_q.delete();
      for (int i = 0; i < l; i++) exp_q.push_back(image[(b + i) % 8]);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst_n = 1'b0; start = 1'b0; base = '0; len = '0; out_ready = 1'b0;
      step(); step();
      check("rst_rom_en",    rom_en,    0);
      check("rst_rom_addr",  rom_addr,  0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data",  out_data,  0);
      check("rst_busy",      busy,      0);
      check("rst_done",      done,      0);
      check("rst_checksum",  checksum,  0);
      rst_n = 1'b1;
      step();

      // base 0, len 4, streaming: exact latency and back-to-back words
      got_q.delete(); done_cnt = 0; out_ready = 1'b1;
      launch(3'd0, 4'd4);
      check("t1_rom_en_e0",   rom_en,   1);
      check("t1_rom_addr_e0", rom_addr, 0);
      check("t1_busy_e0",     busy,     1);
      step();
      check("t1_valid_e1", out_valid, 0);
      step();
      check("t1_valid_e2", out_valid, 1);
      check("t1_data_e2",  out_data,  10);
      step(); check("t1_data_e3", out_data, 11);
      step(); check("t1_data_e4", out_data, 12);
      step(); check("t1_data_e5", out_data, 13);
      step();
      check("t1_done",       done, 1);
      check("t1_busy_fall",  busy, 0);
`ifdef ROM_READER_CHECKSUM_EN
      check("t1_checksum", checksum, 46);
`else
      check("t1_checksum", checksum, 0);
`endif
      step();
      check("t1_done_low",   done,     0);
      check("t1_done_count", done_cnt, 1);
      load_exp(0, 4);
      check_stream("t1_stream");

      // address wrap: base 6, len 4
      got_q.delete();
      launch(3'd6, 4'd4);
      wait_done(30, "t2_done_timeout");
      step();
      load_exp(6, 4);
      check_stream("t2_stream");

      // backpressure: 10 stalled cycles, credit limit of 4 reads
      got_q.delete(); en_cnt = 0; out_ready = 1'b0;
      launch(3'd0, 4'd8);
      for (int i = 0; i < 10; i++) begin
         step();
         if (i >= 1) check($sformatf("t3_hold%0d", i), out_data, 10);
      end
      check("t3_rom_en_pulses", en_cnt,    4);
      check("t3_valid_stall",   out_valid, 1);
      out_ready = 1'b1;
      wait_done(60, "t3_done_timeout");
`ifdef ROM_READER_CHECKSUM_EN
      check("t3_checksum", checksum, 83);
`else
      check("t3_checksum", checksum, 0);
`endif
      step();
      load_exp(0, 8);
      check_stream("t3_stream");

      // len 0 ignored; start during busy ignored
      launch(3'd5, 4'd0);
      check("t4_len0_busy",   busy,   0);
      check("t4_len0_rom_en", rom_en, 0);
      got_q.delete();
      launch(3'd0, 4'd4);
      step();
      launch(3'd3, 4'd4);
      wait_done(30, "t4_done_timeout");
      step();
      check("t4_idle_after", busy, 0);
      step();
      check("t4_no_relaunch", rom_en, 0);
      load_exp(0, 4);
      check_stream("t4_stream");

      // reset after the second delivered word, then a fresh command
      launch(3'd0, 4'd8);   // now just after E0
      step(); step(); step(); step();   // after E4: words 10,11 delivered
      rst_n = 1'b0;
      step();
      check("t5_rom_en",    rom_en,    0);
      check("t5_rom_addr",  rom_addr,  0);
      check("t5_out_valid", out_valid, 0);
      check("t5_out_data",  out_data,  0);
      check("t5_busy",      busy,      0);
      check("t5_done",      done,      0);
      check("t5_checksum",  checksum,  0);
      rst_n = 1'b1;
      step();
      got_q.delete();
      launch(3'd2, 4'd2);
      wait_done(30, "t5_done_timeout");
      step();
      step();
      check("t5_idle", out_valid, 0);
      load_exp(2, 2);
      check_stream("t5_stream");

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
